// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_sync
//  Purpose  : Synchronises a raw asynchronous level into the clk domain,
//             rejects excursions shorter than STABLE_CYCLES samples, and
//             drives a clean registered level plus one-cycle edge pulses.
//  Ports    : clk         - system clock, rising-edge active
//             rst_n       - asynchronous active-low reset
//             d_async     - raw asynchronous input level
//             q           - debounced registered level
//             rise / fall - one-cycle pulses on q 0->1 / 1->0
//             busy        - a candidate transition is being qualified
//             glitch_cnt  - saturating count of rejected transitions
//  Revision : 1.0  initial release
// ============================================================================
module debounce_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                d_async,
  output logic                q,
  output logic                rise,
  output logic                fall,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] S_LOW_STABLE  = 2'd0;
  localparam logic [1:0] S_WAIT_HIGH   = 2'd1;
  localparam logic [1:0] S_HIGH_STABLE = 2'd2;
  localparam logic [1:0] S_WAIT_LOW    = 2'd3;

  // --------------------------------------------------------------------------
  // Synchroniser: a plain shift chain, nothing between the flops.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   d_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_async};
    end
  end

  assign d_sync = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // FSM state and registered outputs
  // --------------------------------------------------------------------------
  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                q_q, q_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                busy_q, busy_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [GLITCH_W-1:0] glitch_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOW_STABLE;
      cnt_q    <= CNT_ZERO;
      q_q      <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  // Saturating increment: holds at all-ones instead of wrapping.
  assign glitch_inc = (glitch_q == {GLITCH_W{1'b1}}) ? glitch_q
                                                     : glitch_q + GLITCH_W'(1);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;

    case (state_q)
      S_LOW_STABLE: begin
        // The first high sample already counts toward the window.
        if (d_sync) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end

      S_WAIT_HIGH: begin
        if (!d_sync) begin
          state_d  = S_LOW_STABLE;
          cnt_d    = CNT_ZERO;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH_STABLE;
          cnt_d   = CNT_ZERO;
          q_d     = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_HIGH_STABLE: begin
        if (!d_sync) begin
          state_d = S_WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end

      S_WAIT_LOW: begin
        if (d_sync) begin
          state_d  = S_HIGH_STABLE;
          cnt_d    = CNT_ZERO;
          glitch_d = glitch_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW_STABLE;
          cnt_d   = CNT_ZERO;
          q_d     = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_LOW_STABLE;
        cnt_d   = CNT_ZERO;
        q_d     = 1'b0;
      end
    endcase

    // busy is registered alongside the state, so it tracks state_q exactly.
    busy_d = (state_d == S_WAIT_HIGH) || (state_d == S_WAIT_LOW);
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    q          = q_q;
    rise       = rise_q;
    fall       = fall_q;
    busy       = busy_q;
    glitch_cnt = glitch_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debounce_sync
//  Purpose  : Self-checking bench for debounce_sync. Instance A uses the
//             default parameters, instance B uses SYNC_STAGES=3,
//             STABLE_CYCLES=2. Edge pulses are matched against a queue of
//             expected (kind, edge index) entries.
//  Revision : 1.0  initial release
// ============================================================================
module tb_debounce_sync;

  localparam int LAT_A = 2 + 4 - 1;
  localparam int LAT_B = 3 + 2 - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       da = 1'b0;
  logic       db = 1'b0;
  logic       q_a, rise_a, fall_a, busy_a;
  logic       q_b, rise_b, fall_b, busy_b;
  logic [7:0] gl_a, gl_b;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  typedef struct {
    logic d;
    logic q;
    logic rise;
    logic fall;
    logic busy;
    int   gl;
  } vec_t;

  typedef struct {
    bit is_rise;
    int at;
  } pulse_t;

  vec_t   tbl[13];
  vec_t   sb[$];
  pulse_t pa[$];
  pulse_t pb[$];

  debounce_sync #(.SYNC_STAGES(2), .STABLE_CYCLES(4), .GLITCH_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .d_async(da),
    .q(q_a), .rise(rise_a), .fall(fall_a), .busy(busy_a), .glitch_cnt(gl_a)
  );

  debounce_sync #(.SYNC_STAGES(3), .STABLE_CYCLES(2), .GLITCH_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .d_async(db),
    .q(q_b), .rise(rise_b), .fall(fall_b), .busy(busy_b), .glitch_cnt(gl_b)
  );

  always #5 clk = ~clk;

  // Edge index: value seen after edge N is N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_a(input bit is_rise, input int at);
    pulse_t p;
    p.is_rise = is_rise;
    p.at      = at;
    pa.push_back(p);
  endtask

  task automatic expect_b(input bit is_rise, input int at);
    pulse_t p;
    p.is_rise = is_rise;
    p.at      = at;
    pb.push_back(p);
  endtask

  // Pulse monitors: every pulse must match the head of its queue, and an
  // expected pulse whose edge passes without a pulse is reported as missing.
  always @(posedge clk) begin
    pulse_t e;
    #1;
    if (rise_a || fall_a) begin
      chk("a_rise_fall_exclusive", {31'd0, rise_a & fall_a}, 0);
      if (pa.size() == 0) begin
        chk("a_unexpected_pulse", {30'd0, rise_a, fall_a}, 0);
      end else begin
        e = pa.pop_front();
        chk("a_pulse_kind", {31'd0, rise_a}, {31'd0, e.is_rise});
        chk("a_pulse_edge", cyc, e.at);
      end
    end else if (pa.size() > 0 && pa[0].at <= cyc) begin
      e = pa.pop_front();
      chk("a_missing_pulse_edge", cyc, -1);
    end
  end

  always @(posedge clk) begin
    pulse_t e;
    #1;
    if (rise_b || fall_b) begin
      chk("b_rise_fall_exclusive", {31'd0, rise_b & fall_b}, 0);
      if (pb.size() == 0) begin
        chk("b_unexpected_pulse", {30'd0, rise_b, fall_b}, 0);
      end else begin
        e = pb.pop_front();
        chk("b_pulse_kind", {31'd0, rise_b}, {31'd0, e.is_rise});
        chk("b_pulse_edge", cyc, e.at);
      end
    end else if (pb.size() > 0 && pb[0].at <= cyc) begin
      e = pb.pop_front();
      chk("b_missing_pulse_edge", cyc, -1);
    end
  end

  initial begin
    vec_t v;
    int   qhigh;
    int   rel_cyc;
    int   c0;

    // Rise qualification then a 2-cycle low glitch while q=1.
    // Row i: drive d, one edge, then expect the outputs.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1};

    // ---------------- reset state ----------------
    repeat (3) step();
    chk("rst_q_a",    {31'd0, q_a}, 0);
    chk("rst_rise_a", {31'd0, rise_a}, 0);
    chk("rst_fall_a", {31'd0, fall_a}, 0);
    chk("rst_busy_a", {31'd0, busy_a}, 0);
    chk("rst_gl_a",   {24'd0, gl_a}, 0);
    chk("rst_q_b",    {31'd0, q_b}, 0);
    chk("rst_gl_b",   {24'd0, gl_b}, 0);
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 13; i++) begin
      da = tbl[i].d;
      sb.push_back(tbl[i]);
      if (tbl[i].rise) expect_a(1'b1, cyc + 1);
      if (tbl[i].fall) expect_a(1'b0, cyc + 1);
      step();
      v = sb.pop_front();
      chk($sformatf("vec%0d_q", i),    {31'd0, q_a},    {31'd0, v.q});
      chk($sformatf("vec%0d_rise", i), {31'd0, rise_a}, {31'd0, v.rise});
      chk($sformatf("vec%0d_fall", i), {31'd0, fall_a}, {31'd0, v.fall});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy_a}, {31'd0, v.busy});
      chk($sformatf("vec%0d_gl", i),   {24'd0, gl_a},   v.gl);
    end

    // ---------------- full 0->1->0 cycle, 100 ns per level ----------------
    da = 1'b0;
    expect_a(1'b0, cyc + 1 + LAT_A);
    repeat (10) step();
    chk("fc_low_q", {31'd0, q_a}, 0);
    da = 1'b1;
    expect_a(1'b1, cyc + 1 + LAT_A);
    qhigh = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        da = 1'b0;
        expect_a(1'b0, cyc + 1 + LAT_A);
      end
      step();
      if (q_a) qhigh++;
    end
    chk("fc_q_high_cycles", qhigh, 10);
    repeat (10) step();
    chk("fc_end_q", {31'd0, q_a}, 0);
    chk("fc_gl", {24'd0, gl_a}, 1);

    // ---------------- toggle every cycle ----------------
    for (int k = 0; k < 600; k++) begin
      da = ~da;
      step();
      if (q_a) qhigh = -1;
    end
    chk("tog_q_never_high", qhigh, 10);
    da = 1'b0;
    repeat (8) step();
    chk("tog_q", {31'd0, q_a}, 0);
    chk("tog_busy", {31'd0, busy_a}, 0);
    chk("tog_gl_saturated", {24'd0, gl_a}, 255);
    repeat (2) begin
      da = 1'b1;
      step();
      da = 1'b0;
      step();
    end
    repeat (6) step();
    chk("tog_gl_holds", {24'd0, gl_a}, 255);

    // ---------------- reset during WAIT_HIGH ----------------
    da = 1'b1;
    repeat (4) step();
    chk("pre_rst_busy", {31'd0, busy_a}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_q",    {31'd0, q_a}, 0);
    chk("async_rst_rise", {31'd0, rise_a}, 0);
    chk("async_rst_fall", {31'd0, fall_a}, 0);
    chk("async_rst_busy", {31'd0, busy_a}, 0);
    chk("async_rst_gl",   {24'd0, gl_a}, 0);
    #13;
    rst_n = 1'b1;
    rel_cyc = cyc;
    expect_a(1'b1, rel_cyc + 1 + LAT_A);
    #5;
    repeat (10) step();
    chk("post_rst_q", {31'd0, q_a}, 1);
    chk("post_rst_gl", {24'd0, gl_a}, 0);

    // ---------------- instance B: SYNC_STAGES=3, STABLE_CYCLES=2 ----------------
    db = 1'b1;
    step();
    db = 1'b0;
    repeat (8) step();
    chk("b_glitch_q", {31'd0, q_b}, 0);
    chk("b_glitch_gl", {24'd0, gl_b}, 1);

    db = 1'b1;
    c0 = cyc;
    expect_b(1'b1, c0 + 1 + LAT_B);
    repeat (2) step();
    db = 1'b0;
    expect_b(1'b0, c0 + 2 + 1 + LAT_B);
    repeat (3) step();
    chk("b_accept_q_high", {31'd0, q_b}, 1);
    repeat (8) step();
    chk("b_accept_q_end", {31'd0, q_b}, 0);
    chk("b_accept_gl", {24'd0, gl_b}, 1);

    // ---------------- wrap-up ----------------
    repeat (4) step();
    chk("a_pending_pulses", pa.size(), 0);
    chk("b_pending_pulses", pb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
